// File: rtl/cva6_tlb_sv32_param.sv
// Fully associative Sv32 TLB: 4 KiB pages and 4 MiB superpages, ASID/global tagging,
// SFENCE.VMA flushes, registered one-cycle lookup, first-invalid then round-robin fill.
module cva6_tlb_sv32_param #(
    parameter int unsigned TLB_ENTRIES   = 4,
    parameter int unsigned ASID_WIDTH    = 9,
    parameter int unsigned CONTENT_WIDTH = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [ASID_WIDTH-1:0]          flush_asid_i,
    input  logic [31:0]                    flush_vaddr_i,
    input  logic                           upd_valid_i,
    input  logic                           upd_is_4M_i,
    input  logic [19:0]                    upd_vpn_i,
    input  logic [ASID_WIDTH-1:0]          upd_asid_i,
    input  logic                           upd_global_i,
    input  logic [CONTENT_WIDTH-1:0]       upd_content_i,
    input  logic                           lu_req_i,
    input  logic [31:0]                    lu_vaddr_i,
    input  logic [ASID_WIDTH-1:0]          lu_asid_i,
    output logic                           lu_valid_o,
    output logic                           lu_hit_o,
    output logic                           lu_is_4M_o,
    output logic [CONTENT_WIDTH-1:0]       lu_content_o,
    output logic [$clog2(TLB_ENTRIES):0]   occupancy_o
);

    localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);
    localparam int unsigned OCC_W = IDX_W + 1;

    logic [TLB_ENTRIES-1:0]   valid_q;
    logic [TLB_ENTRIES-1:0]   global_q;
    logic [TLB_ENTRIES-1:0]   is_4m_q;
    logic [9:0]               vpn1_q    [TLB_ENTRIES];
    logic [9:0]               vpn0_q    [TLB_ENTRIES];
    logic [ASID_WIDTH-1:0]    asid_q    [TLB_ENTRIES];
    logic [CONTENT_WIDTH-1:0] content_q [TLB_ENTRIES];
    logic [IDX_W-1:0]         rr_q;

    logic                     lu_hit_c;
    logic [IDX_W-1:0]         lu_idx_c;
    logic                     upd_match_c;
    logic [IDX_W-1:0]         upd_match_idx_c;
    logic                     inv_found_c;
    logic [IDX_W-1:0]         inv_idx_c;
    logic [IDX_W-1:0]         target_c;
    logic                     evict_c;
    logic                     fill_c;
    logic [TLB_ENTRIES-1:0]   flush_hit_c;
    logic [TLB_ENTRIES-1:0]   valid_d;
    logic [OCC_W-1:0]         occ_c;
    logic                     flush_asid_zero_c;
    logic                     flush_vaddr_zero_c;
    logic                     unused_lu_offset;

    assign unused_lu_offset   = ^lu_vaddr_i[11:0];
    assign fill_c             = upd_valid_i && !flush_i;
    assign flush_asid_zero_c  = (flush_asid_i == '0);
    assign flush_vaddr_zero_c = (flush_vaddr_i == 32'd0);

    // Lookup match, fill target selection and flush victims, all on pre-edge contents.
    always_comb begin
        lu_hit_c        = 1'b0;
        lu_idx_c        = '0;
        upd_match_c     = 1'b0;
        upd_match_idx_c = '0;
        inv_found_c     = 1'b0;
        inv_idx_c       = '0;
        flush_hit_c     = '0;
        for (int e = 0; e < int'(TLB_ENTRIES); e++) begin
            logic vmatch;
            logic amatch;
            if (!lu_hit_c && valid_q[e] && (global_q[e] || asid_q[e] == lu_asid_i) &&
                vpn1_q[e] == lu_vaddr_i[31:22] && (is_4m_q[e] || vpn0_q[e] == lu_vaddr_i[21:12])) begin
                lu_hit_c = 1'b1;
                lu_idx_c = IDX_W'(e);
            end
            if (!upd_match_c && valid_q[e] && asid_q[e] == upd_asid_i && is_4m_q[e] == upd_is_4M_i &&
                vpn1_q[e] == upd_vpn_i[19:10] && (upd_is_4M_i || vpn0_q[e] == upd_vpn_i[9:0])) begin
                upd_match_c     = 1'b1;
                upd_match_idx_c = IDX_W'(e);
            end
            if (!inv_found_c && !valid_q[e]) begin
                inv_found_c = 1'b1;
                inv_idx_c   = IDX_W'(e);
            end
            vmatch = (vpn1_q[e] == flush_vaddr_i[31:22]) &&
                     (is_4m_q[e] || vpn0_q[e] == flush_vaddr_i[21:12]);
            amatch = !global_q[e] && (asid_q[e] == flush_asid_i);
            case ({flush_asid_zero_c, flush_vaddr_zero_c})
                2'b11:   flush_hit_c[e] = 1'b1;
                2'b10:   flush_hit_c[e] = vmatch;
                2'b01:   flush_hit_c[e] = amatch;
                default: flush_hit_c[e] = vmatch && amatch;
            endcase
        end
        evict_c  = !upd_match_c && !inv_found_c;
        target_c = upd_match_c ? upd_match_idx_c : (inv_found_c ? inv_idx_c : rr_q);
    end

    // Next valid vector and its popcount.
    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = valid_q & ~flush_hit_c;
        end else if (upd_valid_i) begin
            valid_d[target_c] = 1'b1;
        end
        occ_c = '0;
        for (int e = 0; e < int'(TLB_ENTRIES); e++) begin
            occ_c = occ_c + OCC_W'(valid_d[e]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= '0;
            rr_q         <= '0;
            lu_valid_o   <= 1'b0;
            lu_hit_o     <= 1'b0;
            lu_is_4M_o   <= 1'b0;
            lu_content_o <= '0;
            occupancy_o  <= '0;
        end else begin
            valid_q     <= valid_d;
            occupancy_o <= occ_c;
            if (fill_c) begin
                global_q[target_c]  <= upd_global_i;
                is_4m_q[target_c]   <= upd_is_4M_i;
                vpn1_q[target_c]    <= upd_vpn_i[19:10];
                vpn0_q[target_c]    <= upd_vpn_i[9:0];
                asid_q[target_c]    <= upd_asid_i;
                content_q[target_c] <= upd_content_i;
                if (evict_c) begin
                    rr_q <= rr_q + IDX_W'(1);
                end
            end
            lu_valid_o   <= lu_req_i;
            lu_hit_o     <= lu_req_i && lu_hit_c;
            lu_is_4M_o   <= lu_req_i && lu_hit_c && is_4m_q[lu_idx_c];
            lu_content_o <= (lu_req_i && lu_hit_c) ? content_q[lu_idx_c] : '0;
        end
    end

endmodule

// File: tb/tb_cva6_tlb_sv32_param.sv
// Directed self-checking bench for cva6_tlb_sv32_param with default parameters.
module tb_cva6_tlb_sv32_param;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [8:0]  flush_asid;
    logic [31:0] flush_vaddr;
    logic        upd_valid;
    logic        upd_is_4m;
    logic [19:0] upd_vpn;
    logic [8:0]  upd_asid;
    logic        upd_global;
    logic [31:0] upd_content;
    logic        lu_req;
    logic [31:0] lu_vaddr;
    logic [8:0]  lu_asid;
    logic        lu_valid;
    logic        lu_hit;
    logic        lu_is_4m;
    logic [31:0] lu_content;
    logic [2:0]  occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    cva6_tlb_sv32_param dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .flush_asid_i  (flush_asid),
        .flush_vaddr_i (flush_vaddr),
        .upd_valid_i   (upd_valid),
        .upd_is_4M_i   (upd_is_4m),
        .upd_vpn_i     (upd_vpn),
        .upd_asid_i    (upd_asid),
        .upd_global_i  (upd_global),
        .upd_content_i (upd_content),
        .lu_req_i      (lu_req),
        .lu_vaddr_i    (lu_vaddr),
        .lu_asid_i     (lu_asid),
        .lu_valid_o    (lu_valid),
        .lu_hit_o      (lu_hit),
        .lu_is_4M_o    (lu_is_4m),
        .lu_content_o  (lu_content),
        .occupancy_o   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic is4m, input logic [19:0] vpn, input logic [8:0] asid,
                        input logic glob, input logic [31:0] content);
        upd_valid = 1'b1; upd_is_4m = is4m; upd_vpn = vpn; upd_asid = asid;
        upd_global = glob; upd_content = content;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [8:0] asid, input logic [31:0] vaddr);
        flush = 1'b1; flush_asid = asid; flush_vaddr = vaddr;
        tick();
        flush = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] vaddr, input logic [8:0] asid);
        lu_req = 1'b1; lu_vaddr = vaddr; lu_asid = asid;
        tick();
        lu_req = 1'b0;
    endtask

    // Checks a completed lookup: valid, hit and payload.
    task automatic expect_lu(input string tag, input logic hit, input logic [31:0] content);
        check({tag, "_valid"}, 32'(lu_valid), 32'd1);
        check({tag, "_hit"}, 32'(lu_hit), 32'(hit));
        check({tag, "_content"}, lu_content, content);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_asid = '0; flush_vaddr = '0;
        upd_valid = 1'b0; upd_is_4m = 1'b0; upd_vpn = '0; upd_asid = '0;
        upd_global = 1'b0; upd_content = '0; lu_req = 1'b0; lu_vaddr = '0; lu_asid = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(lu_valid), 32'd0);
        check("rst_hit", 32'(lu_hit), 32'd0);
        check("rst_is4m", 32'(lu_is_4m), 32'd0);
        check("rst_content", lu_content, 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);

        // 1: basic 4K fill and hit
        fill(1'b0, 20'd10, 9'd1, 1'b0, 32'hFFFF_FFFF);
        lookup(32'h0000_A000, 9'd1);
        expect_lu("t1", 1'b1, 32'hFFFF_FFFF);
        check("t1_is4m", 32'(lu_is_4m), 32'd0);
        check("t1_occ", 32'(occupancy), 32'd1);
        tick();
        check("t1_idle_valid", 32'(lu_valid), 32'd0);
        check("t1_idle_hit", 32'(lu_hit), 32'd0);

        // 2: flush all
        do_flush(9'd0, 32'd0);
        lookup(32'h0000_A000, 9'd1);
        expect_lu("t2", 1'b0, 32'd0);
        check("t2_occ", 32'(occupancy), 32'd0);

        // 3: superpage with ASID tagging
        fill(1'b1, 20'h00400, 9'd2, 1'b0, 32'h1234_5678);
        lookup(32'h007F_F000, 9'd2);
        expect_lu("t3_a2", 1'b1, 32'h1234_5678);
        check("t3_is4m", 32'(lu_is_4m), 32'd1);
        lookup(32'h007F_F000, 9'd3);
        expect_lu("t3_a3", 1'b0, 32'd0);
        check("t3_is4m_miss", 32'(lu_is_4m), 32'd0);
        check("t3_occ", 32'(occupancy), 32'd1);

        // 4: first-invalid allocation then round-robin eviction
        do_flush(9'd0, 32'd0);
        for (int v = 1; v <= 5; v++) fill(1'b0, 20'(v), 9'd1, 1'b0, 32'h100 + 32'(v));
        lookup(32'h0000_1000, 9'd1);
        expect_lu("t4_v1", 1'b0, 32'd0);
        for (int v = 2; v <= 5; v++) begin
            lookup(32'(v) << 12, 9'd1);
            expect_lu($sformatf("t4_v%0d", v), 1'b1, 32'h100 + 32'(v));
        end
        check("t4_occ", 32'(occupancy), 32'd4);
        fill(1'b0, 20'd6, 9'd1, 1'b0, 32'h106);
        lookup(32'h0000_2000, 9'd1);
        expect_lu("t4_v2_evicted", 1'b0, 32'd0);
        lookup(32'h0000_6000, 9'd1);
        expect_lu("t4_v6", 1'b1, 32'h106);
        lookup(32'h0000_3000, 9'd1);
        expect_lu("t4_v3_kept", 1'b1, 32'h103);
        check("t4_occ6", 32'(occupancy), 32'd4);

        // 5: ASID flush spares global entries
        do_flush(9'd0, 32'd0);
        fill(1'b0, 20'd7, 9'd1, 1'b1, 32'h777);
        fill(1'b0, 20'd8, 9'd1, 1'b0, 32'h888);
        do_flush(9'd1, 32'd0);
        lookup(32'h0000_7000, 9'd5);
        expect_lu("t5_global", 1'b1, 32'h777);
        lookup(32'h0000_8000, 9'd1);
        expect_lu("t5_nonglobal", 1'b0, 32'd0);
        check("t5_occ", 32'(occupancy), 32'd1);

        // 6: same-cycle fill invisible to lookup
        upd_valid = 1'b1; upd_is_4m = 1'b0; upd_vpn = 20'd9; upd_asid = 9'd1;
        upd_global = 1'b0; upd_content = 32'h9999;
        lookup(32'h0000_9000, 9'd1);
        upd_valid = 1'b0;
        expect_lu("t6_same_cycle", 1'b0, 32'd0);
        lookup(32'h0000_9000, 9'd1);
        expect_lu("t6_repeat", 1'b1, 32'h9999);

        // same-cycle vaddr flush does not suppress the hit, then takes effect
        fill(1'b0, 20'h11, 9'd3, 1'b0, 32'h1111);
        fill(1'b0, 20'h12, 9'd4, 1'b0, 32'h1212);
        flush = 1'b1; flush_asid = 9'd0; flush_vaddr = 32'h0001_1000;
        lookup(32'h0001_1000, 9'd3);
        flush = 1'b0;
        expect_lu("t6_flush_same_cycle", 1'b1, 32'h1111);
        lookup(32'h0001_1000, 9'd3);
        expect_lu("t6_vaddr_flushed", 1'b0, 32'd0);
        lookup(32'h0001_2000, 9'd4);
        expect_lu("t6_other_kept", 1'b1, 32'h1212);
        check("t6_occ3", 32'(occupancy), 32'd3);

        // fill dropped by a concurrent flush-all
        upd_valid = 1'b1; upd_vpn = 20'd10; upd_asid = 9'd1; upd_content = 32'hAAAA;
        do_flush(9'd0, 32'd0);
        upd_valid = 1'b0;
        lookup(32'h0000_A000, 9'd1);
        expect_lu("t6_fill_dropped", 1'b0, 32'd0);
        check("t6_occ0", 32'(occupancy), 32'd0);

        // reset during a lookup loses the request
        fill(1'b0, 20'd5, 9'd1, 1'b0, 32'h5555);
        rst = 1'b1;
        lookup(32'h0000_5000, 9'd1);
        rst = 1'b0;
        check("rst_mid_valid", 32'(lu_valid), 32'd0);
        check("rst_mid_content", lu_content, 32'd0);
        check("rst_mid_occ", 32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
